// File: rtl/melody_pkg.sv
// ============================================================================
// Module      : melody_pkg
// Description : Note codes, base tone periods, ROM entry layout and FSM
//               state encoding shared by the melody player.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package melody_pkg;

    localparam logic [3:0] NOTE_REST     = 4'd0;
    localparam logic [3:0] NOTE_DO       = 4'd1;
    localparam logic [3:0] NOTE_RE       = 4'd2;
    localparam logic [3:0] NOTE_MI       = 4'd3;
    localparam logic [3:0] NOTE_FA       = 4'd4;
    localparam logic [3:0] NOTE_SOL      = 4'd5;
    localparam logic [3:0] NOTE_LA       = 4'd6;
    localparam logic [3:0] NOTE_XI       = 4'd7;
    localparam logic [3:0] NOTE_HI_OFS   = 4'd8;
    localparam logic [3:0] NOTE_REST_ALT = 4'd15;

    localparam logic [11:0] PER_DO  = 12'd3817;
    localparam logic [11:0] PER_RE  = 12'd3401;
    localparam logic [11:0] PER_MI  = 12'd3030;
    localparam logic [11:0] PER_FA  = 12'd2865;
    localparam logic [11:0] PER_SOL = 12'd2551;
    localparam logic [11:0] PER_LA  = 12'd2272;
    localparam logic [11:0] PER_XI  = 12'd2024;

    typedef struct packed {
        logic [3:0] note;
        logic [1:0] len;
    } rom_entry_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TONE = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Table period for a note code; zero marks a rest (codes 0 and 15).
    function automatic logic [11:0] base_period(input logic [3:0] note);
        logic [3:0]  degree;
        logic [11:0] per;
        degree = (note >= NOTE_HI_OFS) ? note - (NOTE_HI_OFS - 4'd1) : note;
        case (degree)
            NOTE_DO:  per = PER_DO;
            NOTE_RE:  per = PER_RE;
            NOTE_MI:  per = PER_MI;
            NOTE_FA:  per = PER_FA;
            NOTE_SOL: per = PER_SOL;
            NOTE_LA:  per = PER_LA;
            NOTE_XI:  per = PER_XI;
            default:  per = 12'd0;
        endcase
        if (note >= NOTE_HI_OFS) begin
            per = per >> 1;
        end
        return per;
    endfunction

endpackage

`default_nettype wire

// File: rtl/melody_rom.sv
// ============================================================================
// Module      : melody_rom
// Description : Combinational store of the two 16-step songs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module melody_rom
    import melody_pkg::*;
(
    input  logic       i_song,
    input  logic [3:0] i_step,
    output rom_entry_t o_entry
);

    always_comb begin
        o_entry = '{NOTE_REST, 2'd0};
        case ({i_song, i_step})
            5'd0:  o_entry = '{NOTE_DO,                2'd0};
            5'd1:  o_entry = '{NOTE_RE,                2'd0};
            5'd2:  o_entry = '{NOTE_MI,                2'd1};
            5'd3:  o_entry = '{NOTE_FA,                2'd0};
            5'd4:  o_entry = '{NOTE_SOL,               2'd1};
            5'd5:  o_entry = '{NOTE_REST,              2'd3};
            5'd6:  o_entry = '{NOTE_HI_OFS + 4'd1,     2'd0};
            5'd7:  o_entry = '{NOTE_REST_ALT,          2'd1};
            5'd8:  o_entry = '{NOTE_LA,                2'd0};
            5'd9:  o_entry = '{NOTE_XI,                2'd0};
            5'd10: o_entry = '{NOTE_HI_OFS,            2'd1};
            5'd11: o_entry = '{NOTE_XI,                2'd0};
            5'd12: o_entry = '{NOTE_LA,                2'd0};
            5'd13: o_entry = '{NOTE_SOL,               2'd1};
            5'd14: o_entry = '{NOTE_REST,              2'd0};
            5'd15: o_entry = '{NOTE_DO,                2'd3};
            5'd16: o_entry = '{NOTE_SOL,               2'd0};
            5'd17: o_entry = '{NOTE_SOL,               2'd0};
            5'd18: o_entry = '{NOTE_LA,                2'd1};
            5'd19: o_entry = '{NOTE_SOL,               2'd0};
            5'd20: o_entry = '{NOTE_HI_OFS,            2'd1};
            5'd21: o_entry = '{NOTE_HI_OFS + 4'd6,     2'd2};
            5'd22: o_entry = '{NOTE_HI_OFS + 4'd2,     2'd0};
            5'd23: o_entry = '{NOTE_HI_OFS + 4'd3,     2'd3};
            5'd24: o_entry = '{NOTE_MI,                2'd0};
            5'd25: o_entry = '{NOTE_RE,                2'd0};
            5'd26: o_entry = '{NOTE_DO,                2'd1};
            5'd27: o_entry = '{NOTE_REST,              2'd0};
            5'd28: o_entry = '{NOTE_HI_OFS + 4'd4,     2'd0};
            5'd29: o_entry = '{NOTE_HI_OFS + 4'd5,     2'd0};
            5'd30: o_entry = '{NOTE_HI_OFS + 4'd6,     2'd1};
            5'd31: o_entry = '{NOTE_HI_OFS,            2'd3};
            default: o_entry = '{NOTE_REST, 2'd0};
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/melody_player.sv
// ============================================================================
// Module      : melody_player
// Description : Plays one of two stored melodies on a passive buzzer with
//               articulation gaps, loop mode and stop control.
//               Optional macro BEEP_TRANSPOSE_EN adds the octave_up input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module melody_player
    import melody_pkg::*;
#(
    parameter logic [24:0] UNIT_CYC     = 25'd5000000,
    parameter logic [24:0] GAP_CYC      = 25'd500000,
    parameter int          NUM_STEPS    = 8,
    parameter int          PERIOD_W     = 18,
    parameter int          PERIOD_SHIFT = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic       stop,
    input  logic       song_sel,
    input  logic       loop_en,
`ifdef BEEP_TRANSPOSE_EN
    input  logic       octave_up,
`endif
    output logic       beep,
    output logic       busy,
    output logic       done,
    output logic [3:0] step_idx
);

    logic [1:0]          r_state;
    logic                r_song;
    logic [3:0]          r_step;
    logic [1:0]          r_len;
    logic [1:0]          r_dur_cnt;
    logic [24:0]         r_unit_cnt;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_freq_cnt;
    logic                r_rest;
    logic                r_beep;
    logic                r_done;

    logic [1:0]          w_state_next;
    logic                w_load;
    logic [3:0]          w_load_step;
    logic                w_done_next;
    logic                w_rom_song;
    rom_entry_t          w_entry;
    logic [11:0]         w_base;
    logic [PERIOD_W-1:0] w_period;
    logic [PERIOD_W-1:0] w_freq_next;
    logic                w_beep_next;
    logic                w_unit_end;
    logic                w_tone_end;
    logic                w_gap_end;
    logic                w_last_step;

    // The song is taken live from song_sel only on the accepting IDLE cycle.
    assign w_rom_song = (r_state == ST_IDLE) ? song_sel : r_song;

    melody_rom u_rom (
        .i_song  (w_rom_song),
        .i_step  (w_load_step),
        .o_entry (w_entry)
    );

    assign w_base = base_period(w_entry.note);

    always_comb begin
        w_period = PERIOD_W'(32'(w_base) >> PERIOD_SHIFT);
`ifdef BEEP_TRANSPOSE_EN
        if (octave_up) begin
            w_period = w_period >> 1;
        end
`endif
        if (w_period < PERIOD_W'(2)) begin
            w_period = PERIOD_W'(2);
        end
    end

    assign w_unit_end  = (r_unit_cnt == UNIT_CYC - 25'd1);
    assign w_tone_end  = w_unit_end && (r_dur_cnt == r_len);
    assign w_gap_end   = (r_unit_cnt == GAP_CYC - 25'd1);
    assign w_last_step = (r_step == 4'(NUM_STEPS - 1));
    assign w_freq_next = (r_freq_cnt == r_period - PERIOD_W'(1)) ? '0
                                                                 : r_freq_cnt + PERIOD_W'(1);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_step  = r_step;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_TONE;
                    w_load       = 1'b1;
                    w_load_step  = 4'd0;
                end
            end
            ST_TONE: begin
                if (w_tone_end) begin
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_gap_end) begin
                    if (!w_last_step) begin
                        w_state_next = ST_TONE;
                        w_load       = 1'b1;
                        w_load_step  = r_step + 4'd1;
                    end else if (loop_en) begin
                        w_state_next = ST_TONE;
                        w_load       = 1'b1;
                        w_load_step  = 4'd0;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (stop) begin
            w_state_next = ST_IDLE;
            w_load       = 1'b0;
            w_done_next  = 1'b0;
        end
    end

    // Registered beep follows the counter value of the cycle it is shown in.
    assign w_beep_next = (r_state == ST_TONE) && (w_state_next == ST_TONE) && !r_rest
                         && (w_freq_next >= (r_period >> 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= ST_IDLE;
            r_song     <= 1'b0;
            r_step     <= 4'd0;
            r_len      <= 2'd0;
            r_dur_cnt  <= 2'd0;
            r_unit_cnt <= 25'd0;
            r_period   <= '0;
            r_freq_cnt <= '0;
            r_rest     <= 1'b0;
            r_beep     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
            r_beep  <= w_beep_next;
            if (w_load) begin
                r_song     <= w_rom_song;
                r_step     <= w_load_step;
                r_len      <= w_entry.len;
                r_rest     <= (w_base == 12'd0);
                r_period   <= w_period;
                r_freq_cnt <= '0;
                r_unit_cnt <= 25'd0;
                r_dur_cnt  <= 2'd0;
            end else if (w_state_next == ST_IDLE) begin
                r_step     <= 4'd0;
                r_freq_cnt <= '0;
                r_unit_cnt <= 25'd0;
                r_dur_cnt  <= 2'd0;
            end else if (r_state == ST_TONE) begin
                r_freq_cnt <= w_freq_next;
                if (w_tone_end) begin
                    r_unit_cnt <= 25'd0;
                    r_dur_cnt  <= 2'd0;
                end else if (w_unit_end) begin
                    r_unit_cnt <= 25'd0;
                    r_dur_cnt  <= r_dur_cnt + 2'd1;
                end else begin
                    r_unit_cnt <= r_unit_cnt + 25'd1;
                end
            end else begin
                r_unit_cnt <= r_unit_cnt + 25'd1;
            end
        end
    end

    assign beep     = r_beep;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign step_idx = r_step;

endmodule

`default_nettype wire

// File: tb/tb_melody_player.sv
// ============================================================================
// Module      : tb_melody_player
// Description : Randomised scoreboard bench for melody_player; a timeline
//               model queues the expected outputs of every cycle of a play.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_melody_player;

    localparam int UNIT   = 200;
    localparam int GAP    = 20;
    localparam int SHIFT  = 5;
    localparam int STEPS  = 8;
    localparam int PW     = 18;
    localparam int BUDGET = 20000;

    logic       sys_clk;
    logic       sys_rst;
    logic       start;
    logic       stop;
    logic       song_sel;
    logic       loop_en;
`ifdef BEEP_TRANSPOSE_EN
    logic       octave_up;
`endif
    logic       beep;
    logic       busy;
    logic       done;
    logic [3:0] step_idx;

    melody_player #(
        .UNIT_CYC     (25'(UNIT)),
        .GAP_CYC      (25'(GAP)),
        .NUM_STEPS    (STEPS),
        .PERIOD_W     (PW),
        .PERIOD_SHIFT (SHIFT)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (start),
        .stop     (stop),
        .song_sel (song_sel),
        .loop_en  (loop_en),
`ifdef BEEP_TRANSPOSE_EN
        .octave_up(octave_up),
`endif
        .beep     (beep),
        .busy     (busy),
        .done     (done),
        .step_idx (step_idx)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic       beep;
        logic       busy;
        logic       done;
        logic [3:0] idx;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   plan_t;
    int   plan_stop;
    int   plan_busy;

    int song_note [2][8] = '{'{1, 2, 3, 4, 5, 0, 9, 15}, '{5, 5, 6, 5, 8, 14, 10, 11}};
    int song_len  [2][8] = '{'{0, 0, 1, 0, 1, 3, 0, 1},  '{0, 0, 1, 0, 1, 2, 0, 3}};
    int base_per  [7]    = '{3817, 3401, 3030, 2865, 2551, 2272, 2024};

    function automatic int eff_period(int note, bit oct);
        int p;
        if (note == 0 || note == 15) return 0;
        p = (note <= 7) ? base_per[note - 1] : base_per[note - 8] / 2;
        p = (p >> SHIFT) & ((1 << PW) - 1);
        if (oct) p = p >> 1;
        if (p < 2) p = 2;
        return p;
    endfunction

    // Appends one cycle; returns 1 once the cycle carrying stop has been queued.
    function automatic bit add(obs_t o);
        exp_q.push_back(o);
        if (o.busy) plan_busy++;
        if (plan_stop >= 0 && plan_t == plan_stop) begin
            exp_q.push_back('0);
            return 1'b1;
        end
        plan_t++;
        return 1'b0;
    endfunction

    task automatic plan(int song, bit loop, bit oct);
        forever begin
            for (int i = 0; i < STEPS; i++) begin
                int p;
                int n;
                p = eff_period(song_note[song][i], oct);
                n = (song_len[song][i] + 1) * UNIT;
                for (int k = 0; k < n; k++) begin
                    if (add({(p == 0) ? 1'b0 : ((k % p) >= p / 2), 1'b1, 1'b0, 4'(i)})) return;
                end
                for (int k = 0; k < GAP; k++) begin
                    if (add({1'b0, 1'b1, 1'b0, 4'(i)})) return;
                end
            end
            if (!loop) begin
                if (add({1'b0, 1'b0, 1'b1, 4'd0})) return;
                return;
            end
        end
    endtask

    task automatic play(int song, bit loop, int stop_at);
        bit oct;
        int c;
        oct = 1'b0;
`ifdef BEEP_TRANSPOSE_EN
        oct       = 1'($urandom_range(0, 1));
        octave_up = oct;
`endif
        song_sel  = song[0];
        loop_en   = loop;
        start     = 1'b1;
        plan_t    = 0;
        plan_stop = (loop && stop_at < 0) ? 3 * UNIT : stop_at;
        plan_busy = 0;
        plan(song, loop, oct);
        @(negedge sys_clk);
        start    = 1'b0;
        song_sel = ~song_sel;
        c = 0;
        while (exp_q.size() > 0 && c < BUDGET) begin
            stop  = (c == plan_stop);
            start = (c < plan_busy) && ($urandom_range(0, 63) == 0);
            @(negedge sys_clk);
            c++;
        end
        start = 1'b0;
        stop  = 1'b0;
        if (c >= BUDGET) begin
            n_checks++;
            $display("FAIL play_timeout: %0d expected cycles still pending after %0d cycles",
                     exp_q.size(), c);
            exp_q.delete();
        end
    endtask

    task automatic idle_check(int n, bit both);
        start = both;
        stop  = both;
        for (int i = 0; i < n; i++) exp_q.push_back('0);
        repeat (n) @(negedge sys_clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin : monitor
        obs_t e;
        obs_t g;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {beep, busy, done, step_idx};
                n_checks++;
                if (g === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs @%0t: got beep=%0b busy=%0b done=%0b step_idx=%0d, expected beep=%0b busy=%0b done=%0b step_idx=%0d",
                             $time, g.beep, g.busy, g.done, g.idx, e.beep, e.busy, e.done, e.idx);
                end
            end
        end
    end

    initial begin : driver
        int s;
        int l;
        int st;
        sys_rst  = 1'b1;
        start    = 1'b1;
        stop     = 1'b0;
        song_sel = 1'b0;
        loop_en  = 1'b0;
`ifdef BEEP_TRANSPOSE_EN
        octave_up = 1'b0;
`endif
        @(negedge sys_clk);
        for (int i = 0; i < 3; i++) exp_q.push_back('0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        start   = 1'b0;
        idle_check(4, 1'b0);
        idle_check(3, 1'b1);

        play(0, 1'b0, -1);
        play(1, 1'b0, -1);
        play(0, 1'b0, 860 + int'($urandom_range(0, 199)));
        play(0, 1'b0, -1);
        play(1, 1'b1, 3160 + int'($urandom_range(100, 1500)));
        idle_check(2, 1'b0);

        for (int r = 0; r < 3; r++) begin
            s = int'($urandom_range(0, 1));
            l = int'($urandom_range(0, 1));
            if (l != 0)                          st = int'($urandom_range(0, 4000));
            else if ($urandom_range(0, 1) == 0)  st = -1;
            else                                 st = int'($urandom_range(0, 3000));
            play(s, l[0], st);
        end
        idle_check(2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
